// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - in-order stage launcher and shared-RAM port arbiter; optional watchdog via SEQ_WATCHDOG_EN
module stage_sequencer #(
    parameter int N_STAGE = 10,
    parameter int N_RAM   = 4,
    parameter int AW      = 17,
    parameter int DW      = 24,
    parameter int SW      = 4,
    parameter int TO_CYC  = 1 << 20
) (
    input  logic                        iCLK,
    input  logic                        iRST_N,
    input  logic                        iSTART,
    input  logic                        iABORT,
    input  logic [N_STAGE-1:0]          iStg_done,
    input  logic [N_STAGE*N_RAM-1:0]    iStg_wren,
    input  logic [N_STAGE*N_RAM*AW-1:0] iStg_addr,
    input  logic [N_STAGE*N_RAM*DW-1:0] iStg_data,
    output logic [N_STAGE-1:0]          oEna,
    output logic [SW-1:0]               oSTATUS,
    output logic                        oBusy,
    output logic                        oFinish,
    output logic                        oErr,
    output logic [N_RAM-1:0]            oWren,
    output logic [N_RAM*AW-1:0]         oAddr,
    output logic [N_RAM*DW-1:0]         oData
);

    localparam int NP = 1 << SW;
    localparam logic [SW-1:0] LAST = SW'(N_STAGE - 1);

    if ((NP < N_STAGE) || (N_STAGE < 2) || (TO_CYC < 2)) begin : gBadParams
        $error("stage_sequencer: inconsistent parameters");
    end

`ifdef SEQ_WATCHDOG_EN
    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
    localparam int CW = $clog2(TO_CYC) + 1;
    logic [CW-1:0] cntQ, cntD;
    logic          errQ, errD;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    state_t              stateQ, stateD;
    logic [SW-1:0]       statusQ, statusD;
    logic [N_STAGE-1:0]  enaQ, enaD;
    logic                busyQ, busyD;
    logic                finishQ, finishD;
    logic [NP-1:0]       doneExt;

    // Pad done to the full status range so the active-stage lookup never indexes out of range.
    assign doneExt = NP'(iStg_done);

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            stateQ  <= IDLE;
            statusQ <= '0;
            enaQ    <= '0;
            busyQ   <= 1'b0;
            finishQ <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            cntQ    <= '0;
            errQ    <= 1'b0;
`endif
        end else begin
            stateQ  <= stateD;
            statusQ <= statusD;
            enaQ    <= enaD;
            busyQ   <= busyD;
            finishQ <= finishD;
`ifdef SEQ_WATCHDOG_EN
            cntQ    <= cntD;
            errQ    <= errD;
`endif
        end
    end

    always_comb begin
        stateD  = stateQ;
        statusD = statusQ;
        enaD    = '0;
        busyD   = busyQ;
        finishD = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        cntD    = cntQ;
        errD    = errQ;
`endif
        if (iABORT) begin
            stateD  = IDLE;
            statusD = '0;
            busyD   = 1'b0;
`ifdef SEQ_WATCHDOG_EN
            cntD    = '0;
            errD    = 1'b0;
`endif
        end else begin
            case (stateQ)
                IDLE: begin
                    if (iSTART) begin
                        stateD  = RUN;
                        statusD = '0;
                        enaD    = N_STAGE'(1);
                        busyD   = 1'b1;
`ifdef SEQ_WATCHDOG_EN
                        cntD    = '0;
`endif
                    end
                end
                RUN: begin
                    if (doneExt[statusQ]) begin
                        if (statusQ == LAST) begin
                            stateD  = IDLE;
                            statusD = '0;
                            busyD   = 1'b0;
                            finishD = 1'b1;
                        end else begin
                            statusD = statusQ + SW'(1);
                            enaD    = N_STAGE'(1) << (statusQ + SW'(1));
                        end
`ifdef SEQ_WATCHDOG_EN
                        cntD = '0;
                    end else if (cntQ == CW'(TO_CYC - 1)) begin
                        stateD = ERR;
                        errD   = 1'b1;
                        busyD  = 1'b0;
                    end else begin
                        cntD = cntQ + CW'(1);
`endif
                    end
                end
                default: begin
                    // ERR is left only through abort or reset.
                end
            endcase
        end
    end

    // Only the active stage's bus reaches the RAMs; the mux tracks the registered state so a
    // launched stage owns its RAMs in the same cycle its enable pulse is seen.
    always_comb begin
        oWren = '0;
        oAddr = '0;
        oData = '0;
        if (stateQ == RUN) begin
            for (int k = 0; k < N_STAGE; k++) begin
                if (statusQ == SW'(k)) begin
                    oWren = iStg_wren[k*N_RAM +: N_RAM];
                    oAddr = iStg_addr[k*N_RAM*AW +: N_RAM*AW];
                    oData = iStg_data[k*N_RAM*DW +: N_RAM*DW];
                end
            end
        end
    end

    assign oEna    = enaQ;
    assign oSTATUS = statusQ;
    assign oBusy   = busyQ;
    assign oFinish = finishQ;
`ifdef SEQ_WATCHDOG_EN
    assign oErr    = errQ;
`else
    assign oErr    = 1'b0;
`endif

endmodule
